// File: rtl/hms_pkg.sv
// Shared constants for the hour/minute/second counter chain.
package hms_pkg;

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_SETUP = 1'b1
    } mode_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

endpackage

// File: rtl/hms_stage.sv
// One counter stage: count register, wrap detect and registered carry pulse.
// Decrement support is compiled in only with HMS_CNT_CHAIN_DEC_EN.
module hms_stage
    import hms_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic             i_inc,
`ifdef HMS_CNT_CHAIN_DEC_EN
    input  logic             i_dec,
`endif
    input  logic [CNT_W-1:0] i_max,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_at_max,
    output logic             o_carry
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             inc_only;

    // >= so a count stranded above a lowered max still wraps on its next advance.
    assign o_at_max = (cnt_q >= i_max);

`ifdef HMS_CNT_CHAIN_DEC_EN
    assign inc_only = i_inc & ~i_dec;
`else
    assign inc_only = i_inc;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = 1'b0;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_adv) begin
            if (o_at_max) begin
                cnt_d   = '0;
                carry_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (inc_only) begin
            cnt_d = o_at_max ? '0 : cnt_q + 1'b1;
        end
`ifdef HMS_CNT_CHAIN_DEC_EN
        else if (i_dec && !i_inc) begin
            cnt_d = (cnt_q == '0) ? i_max : cnt_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_carry = carry_q;

endmodule

// File: rtl/hms_cnt_chain.sv
// Cascaded wrap counters (e.g. h:m:s) with RUN ripple and SETUP per-stage edits.
// Optional SETUP decrement via macro HMS_CNT_CHAIN_DEC_EN.
module hms_cnt_chain
    import hms_pkg::*;
#(
    parameter  int NUM_STAGES = 3,
    parameter  int CNT_W      = 6,
    localparam int SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_STAGES*CNT_W-1:0] i_max_cnt,
    input  logic                        i_mode,
    input  logic                        i_tick,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic                        i_inc,
    input  logic                        i_dec,
    input  logic                        i_clr,
    output logic [NUM_STAGES*CNT_W-1:0] o_cnt,
    output logic [NUM_STAGES-1:0]       o_carry,
    output logic                        o_all_max
);

    logic                  run_tick;
    logic                  setup;
    logic [NUM_STAGES-1:0] at_max;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] sel_inc;
    logic [NUM_STAGES-1:0] eq_max;

    assign setup    = (i_mode == MODE_SETUP);
    assign run_tick = ~setup & i_tick & ~i_clr;

`ifndef HMS_CNT_CHAIN_DEC_EN
    logic unused_dec;
    assign unused_dec = i_dec;
`endif

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Ripple from register-side wrap flags so the whole chain settles in one cycle.
        if (k == 0) begin : g_lsb
            assign adv[k] = run_tick;
        end else begin : g_upper
            assign adv[k] = run_tick & (&at_max[k-1:0]);
        end

        assign sel_inc[k] = setup & ~i_clr & i_inc & (i_sel == SEL_W'(k));
        assign eq_max[k]  = (o_cnt[k*CNT_W +: CNT_W] == i_max_cnt[k*CNT_W +: CNT_W]);

`ifdef HMS_CNT_CHAIN_DEC_EN
        logic sel_dec;
        assign sel_dec = setup & ~i_clr & i_dec & (i_sel == SEL_W'(k));
`endif

        hms_stage #(.CNT_W(CNT_W)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (i_clr),
            .i_adv    (adv[k]),
            .i_inc    (sel_inc[k]),
`ifdef HMS_CNT_CHAIN_DEC_EN
            .i_dec    (sel_dec),
`endif
            .i_max    (i_max_cnt[k*CNT_W +: CNT_W]),
            .o_cnt    (o_cnt[k*CNT_W +: CNT_W]),
            .o_at_max (at_max[k]),
            .o_carry  (o_carry[k])
        );
    end

    assign o_all_max = &eq_max;

endmodule

// File: tb/tb_hms_cnt_chain.sv
// Directed self-checking bench for hms_cnt_chain at 3 stages x 6 bits, max {23,59,59}.
module tb_hms_cnt_chain;
    import hms_pkg::*;

    localparam int NS = 3;
    localparam int CW = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*CW-1:0] i_max_cnt;
    logic             i_mode, i_tick, i_inc, i_dec, i_clr;
    logic [1:0]       i_sel;
    logic [NS*CW-1:0] o_cnt;
    logic [NS-1:0]    o_carry;
    logic             o_all_max;

    int errors = 0;
    int checks = 0;
    int carries;

    hms_cnt_chain #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_max_cnt (i_max_cnt),
        .i_mode    (i_mode),
        .i_tick    (i_tick),
        .i_sel     (i_sel),
        .i_inc     (i_inc),
        .i_dec     (i_dec),
        .i_clr     (i_clr),
        .o_cnt     (o_cnt),
        .o_carry   (o_carry),
        .o_all_max (o_all_max)
    );

    always #5 clk = ~clk;

    function automatic logic [NS*CW-1:0] hms(input int h, input int m, input int s);
        return {CW'(h), CW'(m), CW'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic setup_inc(input logic [1:0] sel, input int n);
        i_mode = MODE_SETUP;
        i_sel  = sel;
        for (int i = 0; i < n; i++) begin
            i_inc = 1'b1;
            step();
        end
        i_inc  = 1'b0;
        i_mode = MODE_RUN;
    endtask

    task automatic clear();
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        i_max_cnt = hms(HOUR_MAX, MIN_MAX, SEC_MAX);
        i_mode    = MODE_RUN;
        i_tick    = 1'b0;
        i_sel     = 2'd0;
        i_inc     = 1'b0;
        i_dec     = 1'b0;
        i_clr     = 1'b0;
        #2;
        check("reset_cnt", 32'(o_cnt), 32'(hms(0, 0, 0)));
        check("reset_carry", 32'(o_carry), 32'd0);
        check("reset_all_max", 32'(o_all_max), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 60 ticks: exactly one seconds carry, on the last tick
        carries = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_carry[0]) carries++;
            if (i == 59) check("tick60_carry", 32'(o_carry), 32'b001);
        end
        check("tick60_cnt", 32'(o_cnt), 32'(hms(0, 1, 0)));
        check("tick60_pulses", 32'(carries), 32'd1);
        step();
        check("carry_one_cycle", 32'(o_carry), 32'd0);

        // preset to all-max, then full rollover
        clear();
        setup_inc(2'd0, 59);
        setup_inc(2'd1, 59);
        setup_inc(2'd2, 23);
        check("preset_cnt", 32'(o_cnt), 32'(hms(23, 59, 59)));
        check("preset_all_max", 32'(o_all_max), 32'd1);
        i_mode = MODE_SETUP;
        tick();
        i_mode = MODE_RUN;
        check("setup_ignores_tick", 32'(o_cnt), 32'(hms(23, 59, 59)));
        tick();
        check("rollover_cnt", 32'(o_cnt), 32'(hms(0, 0, 0)));
        check("rollover_carry", 32'(o_carry), 32'b111);
        check("rollover_all_max", 32'(o_all_max), 32'd0);
        step();
        check("rollover_carry_clr", 32'(o_carry), 32'd0);

        // SETUP inc wraps the selected stage only
        setup_inc(2'd1, 59);
        setup_inc(2'd0, 5);
        check("setup_pre", 32'(o_cnt), 32'(hms(0, 59, 5)));
        i_mode = MODE_SETUP;
        i_sel  = 2'd1;
        i_inc  = 1'b1;
        step();
        i_inc  = 1'b0;
        check("setup_wrap_cnt", 32'(o_cnt), 32'(hms(0, 0, 5)));
        check("setup_wrap_carry", 32'(o_carry), 32'd0);
        i_mode = MODE_RUN;
        i_inc  = 1'b1;
        step();
        i_inc  = 1'b0;
        check("run_ignores_inc", 32'(o_cnt), 32'(hms(0, 0, 5)));

        // clear beats tick
        clear();
        setup_inc(2'd2, 3);
        setup_inc(2'd1, 4);
        setup_inc(2'd0, 5);
        check("clr_pre", 32'(o_cnt), 32'(hms(3, 4, 5)));
        i_clr  = 1'b1;
        i_tick = 1'b1;
        step();
        i_clr  = 1'b0;
        i_tick = 1'b0;
        check("clr_tick_cnt", 32'(o_cnt), 32'(hms(0, 0, 0)));
        check("clr_tick_carry", 32'(o_carry), 32'd0);

        // out-of-range select
        setup_inc(2'd0, 2);
        setup_inc(2'd3, 1);
        check("sel3_nochange", 32'(o_cnt), 32'(hms(0, 0, 2)));

        // lowered max: minutes stranded at 30 hold, then wrap to 0 on advance
        clear();
        setup_inc(2'd1, 30);
        setup_inc(2'd0, 59);
        i_max_cnt = hms(23, 9, 59);
        step();
        check("lowered_hold", 32'(o_cnt), 32'(hms(0, 30, 59)));
        tick();
        check("lowered_wrap_cnt", 32'(o_cnt), 32'(hms(1, 0, 0)));
        check("lowered_wrap_carry", 32'(o_carry), 32'b011);
        i_max_cnt = hms(HOUR_MAX, MIN_MAX, SEC_MAX);

`ifdef HMS_CNT_CHAIN_DEC_EN
        clear();
        i_mode = MODE_SETUP;
        i_sel  = 2'd2;
        i_dec  = 1'b1;
        step();
        check("dec_wrap", 32'(o_cnt), 32'(hms(23, 0, 0)));
        i_inc  = 1'b1;
        step();
        check("inc_dec_hold", 32'(o_cnt), 32'(hms(23, 0, 0)));
        i_inc  = 1'b0;
        i_dec  = 1'b0;
        i_mode = MODE_RUN;
`else
        clear();
        i_mode = MODE_SETUP;
        i_sel  = 2'd2;
        i_dec  = 1'b1;
        step();
        i_dec  = 1'b0;
        i_mode = MODE_RUN;
        check("dec_ignored", 32'(o_cnt), 32'(hms(0, 0, 0)));
`endif

        // async reset mid-event, then first tick after release counts
        clear();
        setup_inc(2'd0, 7);
        i_tick = 1'b1;
        rst_n  = 1'b0;
        #1;
        check("async_rst_cnt", 32'(o_cnt), 32'(hms(0, 0, 0)));
        check("async_rst_carry", 32'(o_carry), 32'd0);
        step();
        i_tick = 1'b0;
        rst_n  = 1'b1;
        step();
        tick();
        check("post_rst_tick", 32'(o_cnt), 32'(hms(0, 0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
